// File: rtl/clint_mh.sv
// Core-local interruptor: MSIP / MTIMECMP / MTIME registers for NUM_HARTS harts.
// Latency: read data 1 cycle after enb; mtip 1 cycle after the state that causes it.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   rtc_clk           asynchronous time reference, edge-detected after a 2-flop synchroniser
//   mtime_cnt_en      freezes prescaler and mtime when low
//   ena/addra/wea/dina write port, byte-lane enables
//   enb/addrb/doutb   read port, registered data that holds when enb is low
//   msip, mtip        per-hart software / timer interrupt pending
module clint_mh #(
    parameter int NUM_HARTS = 2,
    parameter int TICK_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rtc_clk,
    input  logic                 mtime_cnt_en,
    input  logic                 ena,
    input  logic [15:0]          addra,
    input  logic [3:0]           wea,
    input  logic [31:0]          dina,
    input  logic                 enb,
    input  logic [15:0]          addrb,
    output logic [31:0]          doutb,
    output logic [NUM_HARTS-1:0] msip,
    output logic [NUM_HARTS-1:0] mtip
);

    localparam logic [15:0] A_MTIME_L = 16'hBFF8;
    localparam logic [15:0] A_MTIME_H = 16'hBFFC;
    localparam logic [7:0]  PRESC_MAX = 8'(TICK_DIV - 1);

    logic                 r_rtc_s1;
    logic                 r_rtc_s2;
    logic                 r_rtc_s3;
    logic [7:0]           r_presc;
    logic [63:0]          r_mtime;
    logic [63:0]          r_mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_msip;
    logic [NUM_HARTS-1:0] r_mtip;
    logic [31:0]          r_doutb;

    logic                 w_rtc_tick;
    logic                 w_wr;
    logic                 w_wr_mtime_l;
    logic                 w_wr_mtime_h;
    logic [31:0]          w_rd_dat;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int n = 0; n < 4; n++) begin
            res[8*n +: 8] = be[n] ? new_v[8*n +: 8] : old_v[8*n +: 8];
        end
        return res;
    endfunction

    // r_rtc_s3 is only the edge-detect history; s1/s2 form the synchroniser.
    assign w_rtc_tick   = r_rtc_s2 & ~r_rtc_s3;
    // An all-zero lane mask is treated as no access at all, so it neither
    // blocks the mtime increment nor clears the prescaler.
    assign w_wr         = ena && (wea != 4'b0000);
    assign w_wr_mtime_l = w_wr && (addra == A_MTIME_L);
    assign w_wr_mtime_h = w_wr && (addra == A_MTIME_H);

    always_comb begin
        w_rd_dat = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (addrb == 16'(4 * h))               w_rd_dat = {31'b0, r_msip[h]};
            if (addrb == 16'(32'h4000 + 8 * h))    w_rd_dat = r_mtimecmp[h][31:0];
            if (addrb == 16'(32'h4004 + 8 * h))    w_rd_dat = r_mtimecmp[h][63:32];
        end
        if (addrb == A_MTIME_L) w_rd_dat = r_mtime[31:0];
        if (addrb == A_MTIME_H) w_rd_dat = r_mtime[63:32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rtc_s1 <= 1'b0;
            r_rtc_s2 <= 1'b0;
            r_rtc_s3 <= 1'b0;
            r_presc  <= '0;
            r_mtime  <= '0;
            r_msip   <= '0;
            r_mtip   <= '0;
            r_doutb  <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_mtimecmp[h] <= '1;
            end
        end else begin
            r_rtc_s1 <= rtc_clk;
            r_rtc_s2 <= r_rtc_s1;
            r_rtc_s3 <= r_rtc_s2;

            // Software writes to mtime win over a coincident tick and restart
            // the prescaler so the next increment is a full period away.
            if (w_wr_mtime_l || w_wr_mtime_h) begin
                if (w_wr_mtime_l) r_mtime[31:0]  <= f_merge(r_mtime[31:0],  dina, wea);
                if (w_wr_mtime_h) r_mtime[63:32] <= f_merge(r_mtime[63:32], dina, wea);
                r_presc <= '0;
            end else if (w_rtc_tick && mtime_cnt_en) begin
                if (r_presc == PRESC_MAX) begin
                    r_presc <= '0;
                    r_mtime <= r_mtime + 64'd1;
                end else begin
                    r_presc <= r_presc + 8'd1;
                end
            end

            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_wr && wea[0] && (addra == 16'(4 * h))) begin
                    r_msip[h] <= dina[0];
                end
                if (w_wr && (addra == 16'(32'h4000 + 8 * h))) begin
                    r_mtimecmp[h][31:0] <= f_merge(r_mtimecmp[h][31:0], dina, wea);
                end
                if (w_wr && (addra == 16'(32'h4004 + 8 * h))) begin
                    r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], dina, wea);
                end
                // Compares the current (pre-update) registers, hence one cycle of lag.
                r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
            end

            if (enb) begin
                r_doutb <= w_rd_dat;
            end
        end
    end

    assign doutb = r_doutb;
    assign msip  = r_msip;
    assign mtip  = r_mtip;

endmodule
